pipeline_sequencer: RTL and testbench

- Sequencer that generates the `pipeline_stage` value and the MEM sub-cycle index `cycle_count` consumed by the control unit and the signal generation unit.
- Every instruction is walked through IF -> ID -> EX -> MEM -> WB.
- MEM is stretched to two sub-cycles for instructions that need two bus transfers (RCALL/RET pushing or popping the 16-bit return address), and is further held by bus wait states.
- Also provides a halt/single-step hook and a retired-instruction counter for debug.

---
 rtl/pipeline_sequencer.sv | 100 ++++++++++
 tb/tb_pipeline_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Instruction stage sequencer: walks IF->ID->EX->MEM->WB, stretches MEM for two-transfer
// instructions and bus wait states, and provides halt/single-step and a retired counter.
module pipeline_sequencer #(
    parameter int CNT_WIDTH      = 16,
    parameter int MAX_MEM_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mem_cycles,
    input  logic                 wait_req,
    input  logic                 halt,
    input  logic                 step,
    output logic [2:0]           pipeline_stage,
    output logic                 cycle_count,
    output logic                 instr_retired,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 halted
);

    typedef enum logic [2:0] {
        STAGE_IF  = 3'd0,
        STAGE_ID  = 3'd1,
        STAGE_EX  = 3'd2,
        STAGE_MEM = 3'd3,
        STAGE_WB  = 3'd4
    } stage_t;

    stage_t               stage;
    logic [1:0]           mem_n;
    logic                 mem_idx;
    logic                 step_pending;
    logic [CNT_WIDTH-1:0] retired_q;

    // cycle_count is one bit wide, so no more than two MEM sub-cycles can be indexed.
    function automatic logic [1:0] clamp_mem(input logic [1:0] req);
        int lim;
        lim = (MAX_MEM_CYCLES < 1) ? 1 : ((MAX_MEM_CYCLES > 2) ? 2 : MAX_MEM_CYCLES);
        if (req == 2'd0)
            return 2'd1;
        if (int'(req) > lim)
            return 2'(lim);
        return req;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage        <= STAGE_IF;
            mem_n        <= 2'd1;
            mem_idx      <= 1'b0;
            step_pending <= 1'b0;
            retired_q    <= '0;
        end else begin
            case (stage)
                STAGE_IF: begin
                    if (!halt || step_pending) begin
                        stage        <= STAGE_ID;
                        step_pending <= 1'b0;
                    end else if (step) begin
                        // Only a step seen while parked arms a release; steps in later
                        // stages of a stepped instruction must not release a second one.
                        step_pending <= 1'b1;
                    end
                end
                STAGE_ID: begin
                    stage <= STAGE_EX;
                    mem_n <= clamp_mem(mem_cycles);
                end
                STAGE_EX: begin
                    stage   <= STAGE_MEM;
                    mem_idx <= 1'b0;
                end
                STAGE_MEM: begin
                    if (!wait_req) begin
                        if ({1'b0, mem_idx} < (mem_n - 2'd1)) begin
                            mem_idx <= 1'b1;
                        end else begin
                            stage   <= STAGE_WB;
                            mem_idx <= 1'b0;
                        end
                    end
                end
                STAGE_WB: begin
                    stage     <= STAGE_IF;
                    retired_q <= retired_q + CNT_WIDTH'(1);
                end
                default: begin
                    stage   <= STAGE_IF;
                    mem_idx <= 1'b0;
                end
            endcase
        end
    end

    assign pipeline_stage = stage;
    assign cycle_count    = (stage == STAGE_MEM) ? mem_idx : 1'b0;
    assign instr_retired  = (stage == STAGE_WB);
    assign retired_count  = retired_q;
    assign halted         = !reset && (stage == STAGE_IF) && halt && !step_pending;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: per-cycle stimulus and expected outputs are queued
// together, then replayed one clock at a time against a 16-bit and an 8-bit counter instance.
module tb_pipeline_sequencer;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EX  = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_cycles = 2'd0;
    logic        wait_req = 1'b0;
    logic        halt = 1'b0;
    logic        step = 1'b0;
    logic [2:0]  pipeline_stage;
    logic        cycle_count;
    logic        instr_retired;
    logic [15:0] retired_count;
    logic        halted;
    logic [2:0]  stage_w8;
    logic        cc_w8;
    logic        ret_w8;
    logic [7:0]  count_w8;
    logic        halted_w8;

    always #5 clk = ~clk;

    pipeline_sequencer dut (
        .clk(clk), .reset(reset), .mem_cycles(mem_cycles), .wait_req(wait_req),
        .halt(halt), .step(step), .pipeline_stage(pipeline_stage), .cycle_count(cycle_count),
        .instr_retired(instr_retired), .retired_count(retired_count), .halted(halted)
    );

    pipeline_sequencer #(.CNT_WIDTH(8), .MAX_MEM_CYCLES(2)) dut_w8 (
        .clk(clk), .reset(reset), .mem_cycles(mem_cycles), .wait_req(wait_req),
        .halt(halt), .step(step), .pipeline_stage(stage_w8), .cycle_count(cc_w8),
        .instr_retired(ret_w8), .retired_count(count_w8), .halted(halted_w8)
    );

    typedef struct {
        logic [1:0]  mc;
        logic        wr;
        logic        hl;
        logic        st;
        logic [2:0]  stage;
        logic        cc;
        logic        ret;
        logic        hlt;
        int unsigned cnt;
    } cyc_t;

    cyc_t        q[$];
    int unsigned exp_count = 0;
    int          checks = 0;
    int          passes = 0;
    int          cyc_no = 0;

    task automatic push(input logic [1:0] mc, input logic wr, input logic hl, input logic st,
                        input logic [2:0] stg, input logic cc, input logic ret, input logic hlt);
        cyc_t e;
        e.mc = mc; e.wr = wr; e.hl = hl; e.st = st;
        e.stage = stg; e.cc = cc; e.ret = ret; e.hlt = hlt; e.cnt = exp_count;
        q.push_back(e);
    endtask

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: mem_cycles and wait_req carry noise outside ID / MEM respectively.
    // step_at: 0 = no step, 1 = step during IF, 2 = step during ID.
    task automatic push_instr(input int req, input int wait_sub, input int nwait,
                              input logic hl_early, input logic hl_late, input int step_at);
        int n;
        n = (req == 0) ? 1 : ((req > 2) ? 2 : req);
        push(rnd2(), rnd1(), hl_early, step_at == 1, ST_IF, 1'b0, 1'b0, 1'b0);
        push(2'(req), rnd1(), hl_early, step_at == 2, ST_ID, 1'b0, 1'b0, 1'b0);
        push(rnd2(), rnd1(), hl_late, 1'b0, ST_EX, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < n; s++) begin
            if (s == wait_sub)
                for (int w = 0; w < nwait; w++)
                    push(rnd2(), 1'b1, hl_late, 1'b0, ST_MEM, 1'(s), 1'b0, 1'b0);
            push(rnd2(), 1'b0, hl_late, 1'b0, ST_MEM, 1'(s), 1'b0, 1'b0);
        end
        push(rnd2(), rnd1(), hl_late, 1'b0, ST_WB, 1'b0, 1'b1, 1'b0);
        exp_count++;
    endtask

    task automatic push_park(input int k, input logic step_last);
        for (int i = 0; i < k; i++)
            push(rnd2(), rnd1(), 1'b1, step_last && (i == k - 1), ST_IF, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_queue();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_cycles = e.mc; wait_req = e.wr; halt = e.hl; step = e.st;
            @(negedge clk);
            cyc_no++;
            checks++;
            if (pipeline_stage !== e.stage)
                $display("FAIL stage cyc=%0d got=%0d exp=%0d", cyc_no, pipeline_stage, e.stage);
            else passes++;
            checks++;
            if (cycle_count !== e.cc)
                $display("FAIL cycle_count cyc=%0d got=%0b exp=%0b", cyc_no, cycle_count, e.cc);
            else passes++;
            checks++;
            if (instr_retired !== e.ret)
                $display("FAIL instr_retired cyc=%0d got=%0b exp=%0b", cyc_no, instr_retired, e.ret);
            else passes++;
            checks++;
            if (halted !== e.hlt)
                $display("FAIL halted cyc=%0d got=%0b exp=%0b", cyc_no, halted, e.hlt);
            else passes++;
            checks++;
            if (retired_count !== e.cnt[15:0])
                $display("FAIL retired_count cyc=%0d got=%0d exp=%0d", cyc_no, retired_count, e.cnt[15:0]);
            else passes++;
            checks++;
            if ({stage_w8, cc_w8, ret_w8, halted_w8, count_w8} !== {e.stage, e.cc, e.ret, e.hlt, e.cnt[7:0]})
                $display("FAIL w8_outputs cyc=%0d got=%0h exp=%0h", cyc_no,
                         {stage_w8, cc_w8, ret_w8, halted_w8, count_w8},
                         {e.stage, e.cc, e.ret, e.hlt, e.cnt[7:0]});
            else passes++;
            @(posedge clk); #1;
        end
        step = 1'b0;
        wait_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; halt = 1'b0; step = 1'b0; wait_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; halt = 1'b1; step = 1'b1; wait_req = 1'b1; mem_cycles = 2'd3;
        @(negedge clk);
        checks++;
        if (pipeline_stage !== ST_IF) $display("FAIL reset_stage got=%0d exp=%0d", pipeline_stage, ST_IF);
        else passes++;
        checks++;
        if (cycle_count !== 1'b0) $display("FAIL reset_cycle_count got=%0b exp=0", cycle_count);
        else passes++;
        checks++;
        if (instr_retired !== 1'b0) $display("FAIL reset_instr_retired got=%0b exp=0", instr_retired);
        else passes++;
        checks++;
        if (retired_count !== 16'd0) $display("FAIL reset_retired_count got=%0d exp=0", retired_count);
        else passes++;
        checks++;
        if (halted !== 1'b0) $display("FAIL reset_halted got=%0b exp=0", halted);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b0; halt = 1'b0; step = 1'b0; wait_req = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) push_instr(1, -1, 0, 1'b0, 1'b0, 0);
        run_queue();
    endtask

    task automatic test_two_mem();
        do_reset();
        push_instr(2, -1, 0, 1'b0, 1'b0, 0);
        push_instr(2, -1, 0, 1'b0, 1'b0, 0);
        push_instr(1, -1, 0, 1'b0, 1'b0, 0);
        run_queue();
    endtask

    task automatic test_clamp();
        do_reset();
        push_instr(3, -1, 0, 1'b0, 1'b0, 0);
        push_instr(0, -1, 0, 1'b0, 1'b0, 0);
        push_instr(3, -1, 0, 1'b0, 1'b0, 0);
        run_queue();
    endtask

    task automatic test_wait();
        do_reset();
        push_instr(2, 1, 3, 1'b0, 1'b0, 0);
        push_instr(1, 0, 2, 1'b0, 1'b0, 0);
        push_instr(2, 0, 1, 1'b0, 1'b0, 0);
        run_queue();
    endtask

    task automatic test_halt_step();
        do_reset();
        push_instr(1, -1, 0, 1'b0, 1'b1, 0);
        push_park(20, 1'b0);
        push_park(1, 1'b1);
        push_instr(2, -1, 0, 1'b1, 1'b1, 2);
        push_park(5, 1'b0);
        push_instr(1, -1, 0, 1'b0, 1'b1, 1);
        push_park(4, 1'b0);
        push_instr(1, -1, 0, 1'b0, 1'b0, 0);
        run_queue();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 40; i++)
            push_instr($urandom_range(0, 3), $urandom_range(0, 2) - 1, $urandom_range(0, 3),
                       1'b0, 1'b0, 0);
        run_queue();
    endtask

    task automatic test_async_reset();
        do_reset();
        push_instr(1, -1, 0, 1'b0, 1'b0, 0);
        push(rnd2(), 1'b0, 1'b0, 1'b0, ST_IF, 1'b0, 1'b0, 1'b0);
        push(2'd2, 1'b0, 1'b0, 1'b0, ST_ID, 1'b0, 1'b0, 1'b0);
        push(rnd2(), 1'b0, 1'b0, 1'b0, ST_EX, 1'b0, 1'b0, 1'b0);
        push(rnd2(), 1'b0, 1'b0, 1'b0, ST_MEM, 1'b0, 1'b0, 1'b0);
        run_queue();
        wait_req = 1'b1;
        checks++;
        if (pipeline_stage !== ST_MEM || cycle_count !== 1'b1)
            $display("FAIL pre_reset_mem got=%0d/%0b exp=%0d/1", pipeline_stage, cycle_count, ST_MEM);
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pipeline_stage !== ST_IF || cycle_count !== 1'b0)
            $display("FAIL async_reset_stage got=%0d/%0b exp=%0d/0", pipeline_stage, cycle_count, ST_IF);
        else passes++;
        checks++;
        if (retired_count !== 16'd0 || count_w8 !== 8'd0)
            $display("FAIL async_reset_count got=%0d/%0d exp=0/0", retired_count, count_w8);
        else passes++;
        checks++;
        if (instr_retired !== 1'b0 || halted !== 1'b0)
            $display("FAIL async_reset_flags got=%0b/%0b exp=0/0", instr_retired, halted);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b0; wait_req = 1'b0;
        exp_count = 0;
        push_instr(1, -1, 0, 1'b0, 1'b0, 0);
        run_queue();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) push_instr(1, -1, 0, 1'b0, 1'b0, 0);
        run_queue();
        checks++;
        if (count_w8 !== 8'hFF) $display("FAIL wrap_all_ones got=%0h exp=ff", count_w8);
        else passes++;
        push_instr(1, -1, 0, 1'b0, 1'b0, 0);
        run_queue();
        checks++;
        if (count_w8 !== 8'h00) $display("FAIL wrap_to_zero got=%0h exp=00", count_w8);
        else passes++;
        checks++;
        if (retired_count !== 16'd256) $display("FAIL wide_count got=%0d exp=256", retired_count);
        else passes++;
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_two_mem();
        test_clamp();
        test_wait();
        test_halt_step();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
